ascon_driver: RTL and testbench

ASCON_DRIVER -- requirements
Module: ascon_driver

---
 rtl/ascon_driver_if.sv | 57 +++++
 rtl/ascon_driver.sv | 212 +++++++++++++++++++++
 tb/tb_ascon_driver.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_driver_if.sv
// ----------------------------------------------------------------------------
// ascon_driver_if : bundle of the ports between the ASCON driver and the
// ASCON core.
//
// Handshake: a word moves on a rising edge where valid && ready are both
// high. Once the sender raises valid, it holds valid and the word value
// until that edge. Valid is never dropped before the transfer.
//
//   mode                                  driver -> core  MODE_ENC / MODE_DEC
//   key_in/key_valid/key_ready            key words, MSW first
//   nonce_in/nonce_valid/nonce_ready      nonce words, MSW first
//   assoc_in/assoc_valid/assoc_ready      associated-data words
//   data_in/_valid/_last/_ready           plaintext / ciphertext words
//   data_out/_valid/_last                 core -> driver  result words
//   tag/tag_valid                         core -> driver  final tag
//
// modport master : the driver side.  modport slave : the core side.
// ----------------------------------------------------------------------------
interface ascon_driver_if;
    logic         mode;
    logic [31:0]  key_in;
    logic         key_valid;
    logic         key_ready;
    logic [31:0]  nonce_in;
    logic         nonce_valid;
    logic         nonce_ready;
    logic [31:0]  assoc_in;
    logic         assoc_valid;
    logic         assoc_ready;
    logic [31:0]  data_in;
    logic         data_in_valid;
    logic         data_in_last;
    logic         data_in_ready;
    logic [31:0]  data_out;
    logic         data_out_valid;
    logic         data_out_last;
    logic [127:0] tag;
    logic         tag_valid;

    modport master (
        output mode,
        output key_in, key_valid, input key_ready,
        output nonce_in, nonce_valid, input nonce_ready,
        output assoc_in, assoc_valid, input assoc_ready,
        output data_in, data_in_valid, data_in_last, input data_in_ready,
        input  data_out, data_out_valid, data_out_last, tag, tag_valid
    );

    modport slave (
        input  mode,
        input  key_in, key_valid, output key_ready,
        input  nonce_in, nonce_valid, output nonce_ready,
        input  assoc_in, assoc_valid, output assoc_ready,
        input  data_in, data_in_valid, data_in_last, output data_in_ready,
        output data_out, data_out_valid, data_out_last, tag, tag_valid
    );
endinterface

// File: rtl/ascon_driver.sv
// ----------------------------------------------------------------------------
// ascon_driver : sequences one ASCON AEAD operation into a word-serial core.
// On start it latches the mode, key, nonce and word counts. It then sends the
// 4 key words and the 4 nonce words, MSW first. Next it passes the host stream
// straight through to the core: first the assoc words, then the data words.
// Finally it waits for the tag.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   start, mode_in           command strobe (honoured in IDLE only), mode
//   key, nonce               128-bit key / nonce, latched on start
//   assoc_words, data_words  word counts (data_words == 0 -> len_err pulse)
//   s_data/s_valid/s_ready   host word stream (assoc words, then data words)
//   core                     core-side ports (ascon_driver_if.master)
//   m_data/m_valid/m_last    registered copy of the core result stream
//   tag_q                    last tag seen from the core
//   busy, done, len_err      status
//   dbg_state                current FSM state, for debug
//
// Optional build macro ASCON_DRV_TAG_CHECK_EN adds the input exp_tag and the
// output tag_ok. tag_ok is high after a decrypt whose tag matched exp_tag.
// ----------------------------------------------------------------------------
module ascon_driver #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode_in,
    input  logic [127:0]       key,
    input  logic [127:0]       nonce,
    input  logic [CNT_W-1:0]   assoc_words,
    input  logic [CNT_W-1:0]   data_words,
`ifdef ASCON_DRV_TAG_CHECK_EN
    input  logic [127:0]       exp_tag,
    output logic               tag_ok,
`endif
    input  logic [31:0]        s_data,
    input  logic               s_valid,
    output logic               s_ready,
    ascon_driver_if.master     core,
    output logic [31:0]        m_data,
    output logic               m_valid,
    output logic               m_last,
    output logic [127:0]       tag_q,
    output logic               busy,
    output logic               done,
    output logic               len_err,
    output logic [2:0]         dbg_state
);
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_KEY, S_NONCE, S_ASSOC, S_DATA, S_WAIT_TAG, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         word_q, word_d;
    logic [CNT_W-1:0]   assoc_cnt_q, assoc_cnt_d;
    logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
    logic               mode_q;
    logic [127:0]       key_q, nonce_q, tag_reg_q;
    logic [31:0]        m_data_q;
    logic               m_valid_q, m_last_q;
    logic               len_err_q, len_err_d;
    logic               accept;
    logic [1:0]         word_sel;

    // A start is taken only in IDLE and only with a non-empty data phase.
    assign accept   = (state_q == S_IDLE) && start && (data_words != '0);
    // Word 0 is bits [127:96], so the slice index counts down from 3.
    assign word_sel = 2'd3 - word_q;

    assign core.mode     = mode_q;
    assign core.key_in   = key_q[{word_sel, 5'd0} +: 32];
    assign core.nonce_in = nonce_q[{word_sel, 5'd0} +: 32];
    assign core.assoc_in = s_data;
    assign core.data_in  = s_data;

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign tag_q     = tag_reg_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign len_err   = len_err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d            = state_q;
        word_d             = word_q;
        assoc_cnt_d        = assoc_cnt_q;
        data_cnt_d         = data_cnt_q;
        len_err_d          = 1'b0;
        s_ready            = 1'b0;
        core.key_valid     = 1'b0;
        core.nonce_valid   = 1'b0;
        core.assoc_valid   = 1'b0;
        core.data_in_valid = 1'b0;
        core.data_in_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (data_words == '0)) begin
                    len_err_d = 1'b1;
                end else if (accept) begin
                    state_d     = S_KEY;
                    word_d      = 2'd0;
                    assoc_cnt_d = assoc_words;
                    data_cnt_d  = data_words;
                end
            end
            S_KEY: begin
                core.key_valid = 1'b1;
                if (core.key_ready) begin
                    word_d = word_q + 2'd1;
                    if (word_q == 2'd3) state_d = S_NONCE;
                end
            end
            S_NONCE: begin
                core.nonce_valid = 1'b1;
                if (core.nonce_ready) begin
                    word_d = word_q + 2'd1;
                    if (word_q == 2'd3) state_d = (assoc_cnt_q != '0) ? S_ASSOC : S_DATA;
                end
            end
            S_ASSOC: begin
                core.assoc_valid = s_valid;
                s_ready          = core.assoc_ready;
                if (s_valid && core.assoc_ready) begin
                    if (assoc_cnt_q != '0) assoc_cnt_d = assoc_cnt_q - CNT_W'(1);
                    if (assoc_cnt_q == CNT_W'(1)) state_d = S_DATA;
                end
            end
            S_DATA: begin
                core.data_in_valid = s_valid;
                core.data_in_last  = (data_cnt_q == CNT_W'(1));
                s_ready            = core.data_in_ready;
                if (s_valid && core.data_in_ready) begin
                    if (data_cnt_q != '0) data_cnt_d = data_cnt_q - CNT_W'(1);
                    // A tag arriving with the final word skips WAIT_TAG.
                    if (data_cnt_q == CNT_W'(1)) state_d = core.tag_valid ? S_DONE : S_WAIT_TAG;
                end
            end
            S_WAIT_TAG: begin
                if (core.tag_valid) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            word_q      <= 2'd0;
            assoc_cnt_q <= '0;
            data_cnt_q  <= '0;
            mode_q      <= MODE_ENC;
            key_q       <= '0;
            nonce_q     <= '0;
            tag_reg_q   <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            assoc_cnt_q <= assoc_cnt_d;
            data_cnt_q  <= data_cnt_d;
            len_err_q   <= len_err_d;
            if (accept) begin
                mode_q  <= mode_in;
                key_q   <= key;
                nonce_q <= nonce;
            end
            if (state_q != S_IDLE) begin
                m_valid_q <= core.data_out_valid;
                m_last_q  <= core.data_out_valid & core.data_out_last;
                if (core.data_out_valid) m_data_q <= core.data_out;
                if (core.tag_valid) tag_reg_q <= core.tag;
            end else begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
            end
        end
    end

`ifdef ASCON_DRV_TAG_CHECK_EN
    logic [127:0] exp_tag_q;
    logic         tag_ok_q;

    assign tag_ok = tag_ok_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_tag_q <= '0;
            tag_ok_q  <= 1'b0;
        end else begin
            if (accept) exp_tag_q <= exp_tag;
            if ((state_q == S_IDLE) && start) begin
                tag_ok_q <= 1'b0;
            end else if (state_q == S_DONE) begin
                tag_ok_q <= (tag_reg_q == exp_tag_q) && (mode_q == MODE_DEC);
            end
        end
    end
`endif
endmodule

// File: tb/tb_ascon_driver.sv
// ----------------------------------------------------------------------------
// tb_ascon_driver : directed bench for ascon_driver. The stimulus is one
// linear sequence of steps. A monitor records every core-side transfer, and
// each step's hand-computed expectations are compared against those records.
// ----------------------------------------------------------------------------
module tb_ascon_driver;
  localparam int CNT_W = 8;
  localparam logic [127:0] TAG1 = 128'hdeadbeef_0badf00d_cafebabe_12345678;
  localparam logic [127:0] TAG2 = 128'h01234567_00000000_ffffffff_a5a5a5a5;
  localparam logic [127:0] TAG3 = 128'h31415926_53589793_23846264_33832795;
  localparam logic [127:0] TAG6 = 128'hfeedface_00c0ffee_11111111_22222222;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic               mode_in = 1'b0;
  logic [127:0]       key = '0;
  logic [127:0]       nonce = '0;
  logic [CNT_W-1:0]   assoc_words = '0;
  logic [CNT_W-1:0]   data_words = '0;
  logic [31:0]        s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [31:0]        m_data;
  logic               m_valid, m_last;
  logic [127:0]       tag_q;
  logic               busy, done, len_err;
  logic [2:0]         dbg_state;
`ifdef ASCON_DRV_TAG_CHECK_EN
  logic [127:0]       exp_tag = '0;
  logic               tag_ok;
`endif

  ascon_driver_if cif();

  ascon_driver #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode_in     (mode_in),
    .key         (key),
    .nonce       (nonce),
    .assoc_words (assoc_words),
    .data_words  (data_words),
`ifdef ASCON_DRV_TAG_CHECK_EN
    .exp_tag     (exp_tag),
    .tag_ok      (tag_ok),
`endif
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .core        (cif),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .tag_q       (tag_q),
    .busy        (busy),
    .done        (done),
    .len_err     (len_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- monitor ----------------
  logic [31:0] key_seen[$];
  logic [31:0] nonce_seen[$];
  logic [31:0] assoc_seen[$];
  logic [31:0] data_seen[$];
  logic [31:0] last_seen[$];
  int          assoc_valid_cycles = 0;
  bit          mon_clr = 1'b0;

  always @(posedge clk) begin
    if (mon_clr) begin
      key_seen.delete();
      nonce_seen.delete();
      assoc_seen.delete();
      data_seen.delete();
      last_seen.delete();
      assoc_valid_cycles <= 0;
    end else if (rst) begin
      if (cif.key_valid && cif.key_ready) key_seen.push_back(cif.key_in);
      if (cif.nonce_valid && cif.nonce_ready) nonce_seen.push_back(cif.nonce_in);
      if (cif.assoc_valid && cif.assoc_ready) assoc_seen.push_back(cif.assoc_in);
      if (cif.data_in_valid && cif.data_in_ready) begin
        data_seen.push_back(cif.data_in);
        last_seen.push_back({31'd0, cif.data_in_last});
      end
      if (cif.assoc_valid) assoc_valid_cycles <= assoc_valid_cycles + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] host_q[$];

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_q(input string name);
    check({name, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(name, {96'd0, got_q[i]}, {96'd0, exp_q[i]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    cif.key_ready     = r;
    cif.nonce_ready   = r;
    cif.assoc_ready   = r;
    cif.data_in_ready = r;
  endtask

  // Issues a start and then scrambles the command inputs, so a design that
  // fails to latch them is caught.
  task automatic do_start(input logic m, input logic [127:0] k, input logic [127:0] n,
                          input logic [CNT_W-1:0] na, input logic [CNT_W-1:0] nd);
    mode_in = m; key = k; nonce = n; assoc_words = na; data_words = nd;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode_in = ~m; key = ~k; nonce = ~n; assoc_words = ~na; data_words = ~nd;
  endtask

  // Streams host_q with all cores ready. The tag is returned either with the
  // last data word or once the stream is exhausted. Returns the loop index at
  // which done was seen, or -1 if the cycle budget expires.
  task automatic run_txn(input int max_cyc, input bit tag_with_last, input logic [127:0] tg,
                         output int done_c, output int tag_c);
    int idx = 0;
    bit fire;
    bit tag_sent = 1'b0;
    done_c = -1;
    tag_c  = -1;
    set_ready(1'b1);
    for (int c = 0; c < max_cyc; c++) begin
      s_valid = (idx < host_q.size());
      s_data  = s_valid ? host_q[idx] : 32'd0;
      cif.tag_valid = 1'b0;
      #1;
      if (done) begin
        done_c = c;
        break;
      end
      if (!tag_sent && ((tag_with_last && (idx == host_q.size() - 1) && s_ready) ||
                        (!tag_with_last && (idx == host_q.size())))) begin
        cif.tag_valid = 1'b1;
        cif.tag       = tg;
        tag_sent      = 1'b1;
        tag_c         = c;
      end
      #1;
      fire = s_valid && s_ready;
      tick();
      if (fire) idx++;
    end
    cif.tag_valid = 1'b0;
    s_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int dc, tc;
    set_ready(1'b1);
    cif.data_out = '0; cif.data_out_valid = 1'b0; cif.data_out_last = 1'b0;
    cif.tag = '0; cif.tag_valid = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_state", 128'(dbg_state), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_s_ready", 128'(s_ready), 128'd0);
    check("rst_key_valid", 128'(cif.key_valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_len_err", 128'(len_err), 128'd0);
    check("rst_m_valid", 128'(m_valid), 128'd0);
    check("rst_tag_q", tag_q, 128'd0);
    tick();
    rst = 1'b1;

    // Encrypt with zero key/nonce. The start comes on the first edge after
    // reset release.
    host_q = '{32'h0000_0000, 32'h6e00_0000, 32'h6173_636f};
    do_start(1'b0, 128'd0, 128'd0, 8'd1, 8'd2);
    check("enc_first_start_busy", 128'(busy), 128'd1);
    check("enc_first_start_key_valid", 128'(cif.key_valid), 128'd1);
    run_txn(40, 1'b0, TAG1, dc, tc);
    check("enc_done_cycle", 128'(dc), 128'd12);
    check("enc_tag_cycle", 128'(tc), 128'd11);
    check("enc_tag_q", tag_q, TAG1);
    check("enc_mode", 128'(cif.mode), 128'd0);
    got_q = key_seen;   exp_q = '{0, 0, 0, 0};                  check_q("enc_key");
    got_q = nonce_seen; exp_q = '{0, 0, 0, 0};                  check_q("enc_nonce");
    got_q = assoc_seen; exp_q = '{32'h0};                       check_q("enc_assoc");
    got_q = data_seen;  exp_q = '{32'h6e000000, 32'h6173636f};  check_q("enc_data");
    got_q = last_seen;  exp_q = '{32'd0, 32'd1};                check_q("enc_last");
    tick();
    check("enc_done_one_cycle", 128'(done), 128'd0);
    check("enc_idle_after", 128'(busy), 128'd0);

    // Zero-assoc decrypt. The tag arrives with the single (final) data word.
    clear_mon();
    host_q = '{32'h1122_3344};
    do_start(1'b1, 128'h0f0e0d0c_0b0a0908_07060504_03020100,
             128'h00112233_44556677_8899aabb_ccddeeff, 8'd0, 8'd1);
    run_txn(40, 1'b1, TAG2, dc, tc);
    check("za_done_cycle", 128'(dc), 128'd9);
    check("za_tag_cycle", 128'(tc), 128'd8);
    check("za_tag_q", tag_q, TAG2);
    check("za_mode", 128'(cif.mode), 128'd1);
    check("za_assoc_valid_cycles", 128'(assoc_valid_cycles), 128'd0);
    got_q = key_seen;
    exp_q = '{32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
    check_q("za_key");
    got_q = nonce_seen;
    exp_q = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    check_q("za_nonce");
    got_q = assoc_seen; exp_q = {};                 check_q("za_assoc");
    got_q = data_seen;  exp_q = '{32'h11223344};    check_q("za_data");
    got_q = last_seen;  exp_q = '{32'd1};           check_q("za_last");
    tick();

    // Key backpressure at word 2, start while busy, and the result path
    clear_mon();
    host_q = '{32'ha0000001, 32'ha0000002, 32'hd0000001, 32'hd0000002, 32'hd0000003};
    set_ready(1'b1);
    do_start(1'b0, 128'h01234567_89abcdef_fedcba98_76543210, 128'h5, 8'd2, 8'd3);
    tick();
    tick();
    cif.key_ready = 1'b0;
    #1;
    check("bp_hold1_valid", 128'(cif.key_valid), 128'd1);
    check("bp_hold1_word", 128'(cif.key_in), 128'hfedcba98);
    start = 1'b1; assoc_words = 8'd5; data_words = 8'd0;
    cif.data_out = 32'h5a5aa5a5; cif.data_out_valid = 1'b1; cif.data_out_last = 1'b1;
    tick();
    start = 1'b0;
    cif.data_out_valid = 1'b0; cif.data_out_last = 1'b0;
    #1;
    check("bp_hold2_valid", 128'(cif.key_valid), 128'd1);
    check("bp_hold2_word", 128'(cif.key_in), 128'hfedcba98);
    check("busy_start_no_len_err", 128'(len_err), 128'd0);
    check("m_valid_latency", 128'(m_valid), 128'd1);
    check("m_data", 128'(m_data), 128'h5a5aa5a5);
    check("m_last", 128'(m_last), 128'd1);
    tick();
    #1;
    check("bp_hold3_valid", 128'(cif.key_valid), 128'd1);
    check("bp_hold3_word", 128'(cif.key_in), 128'hfedcba98);
    check("m_valid_drop", 128'(m_valid), 128'd0);
    check("m_last_drop", 128'(m_last), 128'd0);
    run_txn(40, 1'b0, TAG3, dc, tc);
    check("bp_done_cycle", 128'(dc), 128'd12);
    check("bp_tag_q", tag_q, TAG3);
    got_q = key_seen;
    exp_q = '{32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
    check_q("bp_key");
    got_q = assoc_seen; exp_q = '{32'ha0000001, 32'ha0000002};                  check_q("bp_assoc");
    got_q = data_seen;  exp_q = '{32'hd0000001, 32'hd0000002, 32'hd0000003};    check_q("bp_data");
    got_q = last_seen;  exp_q = '{32'd0, 32'd0, 32'd1};                         check_q("bp_last");
    tick();

    // Length error; the result path stays idle in IDLE
    cif.data_out = 32'h77777777; cif.data_out_valid = 1'b1;
    do_start(1'b0, 128'h1, 128'h2, 8'd3, 8'd0);
    check("len_err_pulse", 128'(len_err), 128'd1);
    check("len_err_busy", 128'(busy), 128'd0);
    check("len_err_state", 128'(dbg_state), 128'd0);
    check("idle_no_m_valid", 128'(m_valid), 128'd0);
    cif.data_out_valid = 1'b0;
    tick();
    check("len_err_one_cycle", 128'(len_err), 128'd0);
    check("len_err_busy_after", 128'(busy), 128'd0);

    // Reset mid-DATA, then a fresh transaction
    set_ready(1'b1);
    s_valid = 1'b0;
    do_start(1'b0, 128'h9, 128'h8, 8'd0, 8'd3);
    repeat (8) tick();
    s_valid = 1'b1; s_data = 32'habcd0123;
    #1;
    check("mid_data_valid", 128'(cif.data_in_valid), 128'd1);
    check("mid_data_state", 128'(dbg_state), 128'd4);
    rst = 1'b0;
    #1;
    check("arst_state", 128'(dbg_state), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_s_ready", 128'(s_ready), 128'd0);
    check("arst_data_valid", 128'(cif.data_in_valid), 128'd0);
    check("arst_data_last", 128'(cif.data_in_last), 128'd0);
    check("arst_key_valid", 128'(cif.key_valid), 128'd0);
    check("arst_nonce_valid", 128'(cif.nonce_valid), 128'd0);
    check("arst_done", 128'(done), 128'd0);
    check("arst_m_valid", 128'(m_valid), 128'd0);
    check("arst_tag_q", tag_q, 128'd0);
    s_valid = 1'b0;
    clear_mon();
    rst = 1'b1;
    host_q = '{32'h99887766};
    do_start(1'b1, 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd, 128'h3, 8'd0, 8'd1);
    check("post_rst_key_word0", 128'(cif.key_in), 128'haaaaaaaa);
    run_txn(40, 1'b0, TAG6, dc, tc);
    check("post_rst_done_cycle", 128'(dc), 128'd10);
    check("post_rst_tag_q", tag_q, TAG6);
    got_q = data_seen; exp_q = '{32'h99887766}; check_q("post_rst_data");
    tick();

`ifdef ASCON_DRV_TAG_CHECK_EN
    // Tag check: a matching decrypt tag sets tag_ok, a mismatch leaves it 0
    host_q = '{32'h1};
    exp_tag = TAG1;
    do_start(1'b1, 128'h0, 128'h0, 8'd0, 8'd1);
    exp_tag = '0;
    run_txn(40, 1'b0, TAG1, dc, tc);
    tick();
    check("tag_ok_match", 128'(tag_ok), 128'd1);
    tick();
    check("tag_ok_hold", 128'(tag_ok), 128'd1);
    exp_tag = TAG1 ^ 128'd1;
    do_start(1'b1, 128'h0, 128'h0, 8'd0, 8'd1);
    exp_tag = TAG1;
    check("tag_ok_clear_on_start", 128'(tag_ok), 128'd0);
    run_txn(40, 1'b0, TAG1, dc, tc);
    tick();
    check("tag_ok_mismatch", 128'(tag_ok), 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
